// File: rtl/text_executor.sv
// -----------------------------------------------------------------------------
// text_executor
//   Executes text-mode instructions issued by the CPU register block against a
//   character/attribute video RAM of COLS x ROWS cells.
//
//   Opcodes: 0x00 TEXT_WRITE    write {arg1, arg0} at the cursor, advance cursor
//            0x01 TEXT_POSITION move the cursor to (arg0, arg1)
//            0x02 TEXT_CLEAR    fill every cell with {arg0, 8'h20}, home cursor
//            0x03 GET_TEXT_AT   read cell (arg0, arg1) into result_1/result_0
//
// Ports
//   phi2, reset_n            clock (rising edge) and synchronous active-low reset
//   instruction, arg_data    opcode and argument bytes, valid with the start pulse
//   instruction_start        one-cycle start pulse, accepted only when idle
//   instruction_busy         high from acceptance through the DONE cycle
//   instruction_finished     one-cycle completion pulse
//   instruction_error        level, last instruction failed
//   result_0 / result_1      character / attribute returned by GET_TEXT_AT
//   cursor_col / cursor_row  current cursor position
//   vram_*                   req/ack memory port; a same-cycle ack is accepted
// -----------------------------------------------------------------------------
module text_executor #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        phi2,
  input  logic        reset_n,
  input  logic [7:0]  instruction,
  input  logic [7:0]  arg_data [0:10],
  input  logic        instruction_start,
  output logic        instruction_busy,
  output logic        instruction_finished,
  output logic        instruction_error,
  output logic [7:0]  result_0,
  output logic [7:0]  result_1,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        vram_req,
  output logic        vram_we,
  output logic [11:0] vram_addr,
  output logic [15:0] vram_wdata,
  input  logic        vram_ack,
  input  logic [15:0] vram_rdata
);

  localparam logic [7:0]  OP_WRITE    = 8'h00;
  localparam logic [7:0]  OP_POSITION = 8'h01;
  localparam logic [7:0]  OP_CLEAR    = 8'h02;
  localparam logic [7:0]  OP_GET      = 8'h03;

  localparam logic [7:0]  COLS_B    = 8'(COLS);
  localparam logic [7:0]  ROWS_B    = 8'(ROWS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_CLEAR, S_DONE} state_t;

  state_t      state_q;
  logic [7:0]  op_q, arg0_q, arg1_q;
  logic        busy_q, finished_q, error_q, err_pend_q;
  logic [7:0]  result_0_q, result_1_q;
  logic [6:0]  cursor_col_q;
  logic [4:0]  cursor_row_q;
  logic        vram_req_q, vram_we_q;
  logic [11:0] vram_addr_q;
  logic [15:0] vram_wdata_q;

  // Argument bytes beyond the first two are not used by any opcode.
  logic unused_args;
  assign unused_args = ^{arg_data[2], arg_data[3], arg_data[4], arg_data[5],
                         arg_data[6], arg_data[7], arg_data[8], arg_data[9],
                         arg_data[10]};

  // Cursor position after a completed write, and the linear cell addresses.
  logic [6:0]  adv_col_d;
  logic [4:0]  adv_row_d;
  logic [11:0] cursor_addr_d, arg_addr_d;
  logic        arg_in_range_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    adv_col_d = cursor_col_q + 7'd1;
    adv_row_d = cursor_row_q;
    if (cursor_col_q == LAST_COL) begin
      adv_col_d = 7'd0;
      adv_row_d = (cursor_row_q == LAST_ROW) ? 5'd0 : cursor_row_q + 5'd1;
    end
    cursor_addr_d  = 12'(cursor_row_q) * 12'(COLS) + 12'(cursor_col_q);
    arg_addr_d     = 12'(arg1_q) * 12'(COLS) + 12'(arg0_q);
    arg_in_range_d = (arg0_q < COLS_B) && (arg1_q < ROWS_B);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge phi2) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= 8'h00;
      arg0_q       <= 8'h00;
      arg1_q       <= 8'h00;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      error_q      <= 1'b0;
      err_pend_q   <= 1'b0;
      result_0_q   <= 8'h00;
      result_1_q   <= 8'h00;
      cursor_col_q <= 7'd0;
      cursor_row_q <= 5'd0;
      vram_req_q   <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= 12'd0;
      vram_wdata_q <= 16'h0000;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instruction_start) begin
            op_q       <= instruction;
            arg0_q     <= arg_data[0];
            arg1_q     <= arg_data[1];
            error_q    <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_EXEC;
          end
        end

        // Requests are raised on the edge that enters MEM/CLEAR so that a
        // tied-high ack completes in the first MEM/CLEAR cycle.
        S_EXEC: begin
          case (op_q)
            OP_WRITE: begin
              vram_req_q   <= 1'b1;
              vram_we_q    <= 1'b1;
              vram_addr_q  <= cursor_addr_d;
              vram_wdata_q <= {arg1_q, arg0_q};
              state_q      <= S_MEM;
            end
            OP_POSITION: begin
              if (arg_in_range_d) begin
                cursor_col_q <= arg0_q[6:0];
                cursor_row_q <= arg1_q[4:0];
              end else begin
                err_pend_q <= 1'b1;
              end
              finished_q <= 1'b1;
              state_q    <= S_DONE;
            end
            OP_CLEAR: begin
              vram_req_q   <= 1'b1;
              vram_we_q    <= 1'b1;
              vram_addr_q  <= 12'd0;
              vram_wdata_q <= {arg0_q, 8'h20};
              state_q      <= S_CLEAR;
            end
            OP_GET: begin
              if (arg_in_range_d) begin
                vram_req_q  <= 1'b1;
                vram_we_q   <= 1'b0;
                vram_addr_q <= arg_addr_d;
                state_q     <= S_MEM;
              end else begin
                err_pend_q <= 1'b1;
                finished_q <= 1'b1;
                state_q    <= S_DONE;
              end
            end
            default: begin
              err_pend_q <= 1'b1;
              finished_q <= 1'b1;
              state_q    <= S_DONE;
            end
          endcase
        end

        S_MEM: begin
          if (vram_ack) begin
            if (vram_we_q) begin
              cursor_col_q <= adv_col_d;
              cursor_row_q <= adv_row_d;
            end else begin
              result_0_q <= vram_rdata[7:0];
              result_1_q <= vram_rdata[15:8];
            end
            vram_req_q <= 1'b0;
            vram_we_q  <= 1'b0;
            finished_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end

        // One cell per ack; the request stays up across cells so a
        // combinational ack gives one write per cycle.
        S_CLEAR: begin
          if (vram_ack) begin
            if (vram_addr_q == LAST_ADDR) begin
              vram_req_q   <= 1'b0;
              vram_we_q    <= 1'b0;
              cursor_col_q <= 7'd0;
              cursor_row_q <= 5'd0;
              finished_q   <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              vram_addr_q <= vram_addr_q + 12'd1;
            end
          end
        end

        // Error is published one cycle after finished, never coincident.
        S_DONE: begin
          busy_q  <= 1'b0;
          error_q <= err_pend_q;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instruction_busy     = busy_q;
  assign instruction_finished = finished_q;
  assign instruction_error    = error_q;
  assign result_0             = result_0_q;
  assign result_1             = result_1_q;
  assign cursor_col           = cursor_col_q;
  assign cursor_row           = cursor_row_q;
  assign vram_req             = vram_req_q;
  assign vram_we              = vram_we_q;
  assign vram_addr            = vram_addr_q;
  assign vram_wdata           = vram_wdata_q;

endmodule

// File: tb/tb_text_executor.sv
// -----------------------------------------------------------------------------
// tb_text_executor
//   Directed bench for text_executor (COLS=80, ROWS=30). A small VRAM port
//   model acks either combinationally or under manual control; a negedge
//   monitor counts completed transfers and checks the CLEAR address sequence.
// -----------------------------------------------------------------------------
module tb_text_executor;

  logic        phi2 = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  instruction = 8'h00;
  logic [7:0]  arg_data [0:10];
  logic        instruction_start = 1'b0;
  logic        instruction_busy, instruction_finished, instruction_error;
  logic [7:0]  result_0, result_1;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        vram_req, vram_we;
  logic [11:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        vram_ack;
  logic [15:0] vram_rdata = 16'h0000;

  logic        ack_auto = 1'b1;
  logic        ack_man  = 1'b0;
  assign vram_ack = ack_auto ? vram_req : ack_man;

  text_executor #(.COLS(80), .ROWS(30)) dut (
    .phi2                 (phi2),
    .reset_n              (reset_n),
    .instruction          (instruction),
    .arg_data             (arg_data),
    .instruction_start    (instruction_start),
    .instruction_busy     (instruction_busy),
    .instruction_finished (instruction_finished),
    .instruction_error    (instruction_error),
    .result_0             (result_0),
    .result_1             (result_1),
    .cursor_col           (cursor_col),
    .cursor_row           (cursor_row),
    .vram_req             (vram_req),
    .vram_we              (vram_we),
    .vram_addr            (vram_addr),
    .vram_wdata           (vram_wdata),
    .vram_ack             (vram_ack),
    .vram_rdata           (vram_rdata)
  );

  always #5 phi2 = ~phi2;

  int cyc = 0;
  always @(posedge phi2) cyc++;

  // Transfer monitor, sampled mid-cycle: req&ack here completes at next edge.
  int          wr_cnt = 0, rd_cnt = 0, req_cycles = 0, fin_cnt = 0;
  logic [11:0] last_addr = '0;
  logic [15:0] last_data = '0;
  bit          clr_chk = 1'b0;
  int          clr_exp_addr = 0, clr_bad = 0;

  always @(negedge phi2) begin
    if (vram_req) req_cycles++;
    if (instruction_finished) fin_cnt++;
    if (vram_req && vram_ack) begin
      if (vram_we) begin
        wr_cnt++;
        last_addr = vram_addr;
        last_data = vram_wdata;
        if (clr_chk) begin
          if (vram_addr !== 12'(clr_exp_addr) || vram_wdata !== 16'h0720) clr_bad++;
          clr_exp_addr++;
        end
      end else begin
        rd_cnt++;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one instruction at a negedge and returns cycles until finished
  // (-1 on timeout). With dbl set a second start (POSITION 3,3) is held
  // into the first busy cycle; it must be ignored.
  task automatic run(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                     input bit dbl, output int lat);
    int s;
    @(negedge phi2);
    instruction = op; arg_data[0] = a0; arg_data[1] = a1;
    instruction_start = 1'b1;
    s = cyc;
    @(negedge phi2);
    if (dbl) begin
      instruction = 8'h01; arg_data[0] = 8'd3; arg_data[1] = 8'd3;
    end else begin
      instruction_start = 1'b0;
    end
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      if (instruction_finished) begin
        lat = cyc - s;
        break;
      end
      @(negedge phi2);
      instruction_start = 1'b0;
    end
    instruction_start = 1'b0;
  endtask

  int lat, base_wr, base_rd, base_req, base_fin;

  initial begin
    for (int i = 0; i <= 10; i++) arg_data[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge phi2);
    check("rst_busy", 32'(instruction_busy), 32'd0);
    check("rst_fin_err", {30'd0, instruction_finished, instruction_error}, 32'd0);
    check("rst_vram_ctl", {30'd0, vram_req, vram_we}, 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_vram_wdata", 32'(vram_wdata), 32'd0);
    check("rst_results", {16'd0, result_1, result_0}, 32'd0);
    check("rst_cursor", {20'd0, cursor_col, cursor_row}, 32'd0);
    reset_n = 1'b1;
    @(negedge phi2);

    // POSITION (79,29), then WRITE at the last cell: cursor wraps to (0,0)
    run(8'h01, 8'd79, 8'd29, 1'b0, lat);
    check("pos_lat", 32'(lat), 32'd2);
    check("pos_cursor", {20'd0, cursor_col, cursor_row}, {20'd0, 7'd79, 5'd29});
    base_wr = wr_cnt;
    run(8'h00, 8'h41, 8'h1F, 1'b0, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_count", 32'(wr_cnt - base_wr), 32'd1);
    check("wr_addr_last", 32'(last_addr), 32'd2399);
    check("wr_data_last", 32'(last_data), 32'h1F41);
    check("wr_cursor_wrap", {20'd0, cursor_col, cursor_row}, 32'd0);
    @(negedge phi2);
    check("wr_busy_after", 32'(instruction_busy), 32'd0);
    check("wr_no_error", 32'(instruction_error), 32'd0);

    // Mid-screen write and end-of-row wrap to next row
    run(8'h01, 8'd3, 8'd4, 1'b0, lat);
    run(8'h00, 8'h42, 8'h07, 1'b0, lat);
    check("wr_addr_mid", 32'(last_addr), 32'd323);
    check("wr_data_mid", 32'(last_data), 32'h0742);
    check("wr_cursor_mid", {20'd0, cursor_col, cursor_row}, {20'd0, 7'd4, 5'd4});
    run(8'h01, 8'd79, 8'd5, 1'b0, lat);
    run(8'h00, 8'h43, 8'h00, 1'b0, lat);
    check("wr_addr_eol", 32'(last_addr), 32'd479);
    check("wr_cursor_eol", {20'd0, cursor_col, cursor_row}, {20'd0, 7'd0, 5'd6});

    // POSITION out of range: error one cycle after finished, cursor unchanged
    run(8'h01, 8'd80, 8'd0, 1'b0, lat);
    check("pos_bad_lat", 32'(lat), 32'd2);
    check("pos_bad_err_at_fin", 32'(instruction_error), 32'd0);
    @(negedge phi2);
    check("pos_bad_err", 32'(instruction_error), 32'd1);
    check("pos_bad_cursor", {20'd0, cursor_col, cursor_row}, {20'd0, 7'd0, 5'd6});
    repeat (2) @(negedge phi2);
    check("err_holds", 32'(instruction_error), 32'd1);
    run(8'h01, 8'd0, 8'd30, 1'b0, lat);
    @(negedge phi2);
    check("pos_bad_row_err", 32'(instruction_error), 32'd1);
    run(8'h01, 8'd10, 8'd5, 1'b0, lat);
    @(negedge phi2);
    check("err_cleared", 32'(instruction_error), 32'd0);

    // GET out of range: error, no read, results hold
    base_rd = rd_cnt;
    base_req = req_cycles;
    run(8'h03, 8'd80, 8'd2, 1'b0, lat);
    check("get_bad_lat", 32'(lat), 32'd2);
    check("get_bad_noreq", 32'(req_cycles - base_req), 32'd0);
    @(negedge phi2);
    check("get_bad_err", 32'(instruction_error), 32'd1);
    check("get_bad_results", {16'd0, result_1, result_0}, 32'd0);

    // GET (5,2) with ack delayed three cycles
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    @(negedge phi2);
    instruction = 8'h03; arg_data[0] = 8'd5; arg_data[1] = 8'd2;
    instruction_start = 1'b1;
    @(negedge phi2);
    instruction_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge phi2);
      check("get_hold_req", {19'd0, vram_req, vram_we, vram_addr}, {19'd0, 1'b1, 1'b0, 12'd165});
    end
    @(negedge phi2);
    check("get_results_before", {16'd0, result_1, result_0}, 32'd0);
    check("get_fin_before", 32'(instruction_finished), 32'd0);
    vram_rdata = 16'h4E58;
    ack_man = 1'b1;
    @(negedge phi2);
    ack_man = 1'b0;
    vram_rdata = 16'h0000;
    check("get_fin", 32'(instruction_finished), 32'd1);
    check("get_results", {16'd0, result_1, result_0}, 32'h4E58);
    check("get_req_drop", 32'(vram_req), 32'd0);
    ack_auto = 1'b1;
    @(negedge phi2);
    check("get_no_error", 32'(instruction_error), 32'd0);

    // Unknown opcode with a second start during busy
    base_req = req_cycles;
    base_fin = fin_cnt;
    run(8'h10, 8'd0, 8'd0, 1'b1, lat);
    check("bad_op_lat", 32'(lat), 32'd2);
    @(negedge phi2);
    check("bad_op_err", 32'(instruction_error), 32'd1);
    repeat (5) @(negedge phi2);
    check("bad_op_noreq", 32'(req_cycles - base_req), 32'd0);
    check("bad_op_one_fin", 32'(fin_cnt - base_fin), 32'd1);
    check("bad_op_cursor", {20'd0, cursor_col, cursor_row}, {20'd0, 7'd10, 5'd5});
    check("bad_op_idle", 32'(instruction_busy), 32'd0);
    check("results_hold", {16'd0, result_1, result_0}, 32'h4E58);

    // Full CLEAR with ack tied high
    base_wr = wr_cnt;
    clr_exp_addr = 0;
    clr_bad = 0;
    clr_chk = 1'b1;
    run(8'h02, 8'h07, 8'h00, 1'b0, lat);
    check("clr_lat", 32'(lat), 32'd2402);
    @(negedge phi2);
    clr_chk = 1'b0;
    check("clr_count", 32'(wr_cnt - base_wr), 32'd2400);
    check("clr_sequence", 32'(clr_bad), 32'd0);
    check("clr_cursor", {20'd0, cursor_col, cursor_row}, 32'd0);
    check("clr_busy_after", 32'(instruction_busy), 32'd0);

    // Reset in the middle of a CLEAR
    run(8'h01, 8'd10, 8'd5, 1'b0, lat);
    base_wr = wr_cnt;
    @(negedge phi2);
    instruction = 8'h02; arg_data[0] = 8'h07;
    instruction_start = 1'b1;
    @(negedge phi2);
    instruction_start = 1'b0;
    for (int k = 0; k < 200 && (wr_cnt - base_wr) < 100; k++) @(negedge phi2);
    check("mid_clr_reached", 32'((wr_cnt - base_wr) >= 100), 32'd1);
    reset_n = 1'b0;
    @(negedge phi2);
    check("mid_clr_busy", 32'(instruction_busy), 32'd0);
    check("mid_clr_req", 32'(vram_req), 32'd0);
    check("mid_clr_cursor", {20'd0, cursor_col, cursor_row}, 32'd0);
    check("mid_clr_err", 32'(instruction_error), 32'd0);
    reset_n = 1'b1;
    base_req = req_cycles;
    repeat (5) @(negedge phi2);
    check("mid_clr_noreq", 32'(req_cycles - base_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
